target_tracker: RTL and testbench

- Successor to the single-pass per-row target latch in marker_detect.
- Tracks up to NUM_TARGETS circular markers across video frames. Inputs are row-level detection events from count_flips: centre x, row y, diameter and a non-target score, where lower is better.
- Each event is matched against the slot table by squared distance. The block then updates, allocates or replaces a slot, ages out slots not seen for MAX_MISS frames, and publishes a registered per-frame snapshot to the overlay/pointer logic.
- New versus the previous block: valid/ready handshake, sequential slot scan, score-based replacement when the table is full, frame aging, and a coherent snapshot.

---
 rtl/marker_pkg.sv | 27 ++
 rtl/target_match.sv | 25 ++
 rtl/target_tracker.sv | 186 ++++++++++++++++++
 tb/tb_target_tracker.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/marker_pkg.sv
// Shared widths, slot record and FSM encoding for the marker target tracker.
package marker_pkg;
  localparam int SCREEN_WIDTH  = 1280;
  localparam int SCREEN_HEIGHT = 720;
  localparam int SCORE_W       = 11;
  localparam int XW            = $clog2(SCREEN_WIDTH) + 1;
  localparam int YW            = $clog2(SCREEN_HEIGHT) + 1;
  localparam int DW            = 2 * XW + 1;

  typedef struct packed {
    logic [XW-1:0]      x;
    logic [YW-1:0]      y;
    logic [YW-1:0]      diam;
    logic [SCORE_W-1:0] score;
    logic [3:0]         age;
    logic               seen;
    logic               valid;
  } target_slot_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_COMMIT,
    ST_AGE,
    ST_PUBLISH
  } tracker_state_t;
endpackage

// File: rtl/target_match.sv
// Combinational circle test of one detection against one slot (squared distance vs diameter squared).
module target_match
  import marker_pkg::*;
(
  input  logic [XW-1:0] slot_x,
  input  logic [YW-1:0] slot_y,
  input  logic [YW-1:0] slot_diam,
  input  logic          slot_valid,
  input  logic [XW-1:0] ev_x,
  input  logic [YW-1:0] ev_y,
  output logic          hit,
  output logic [DW-1:0] dist_sq
);
  logic [XW-1:0] adx;
  logic [YW-1:0] ady;
  logic [DW-1:0] diam_sq;

  always_comb begin
    adx     = (ev_x >= slot_x) ? (ev_x - slot_x) : (slot_x - ev_x);
    ady     = (ev_y >= slot_y) ? (ev_y - slot_y) : (slot_y - ev_y);
    dist_sq = DW'(adx) * DW'(adx) + DW'(ady) * DW'(ady);
    diam_sq = DW'(slot_diam) * DW'(slot_diam);
    hit     = slot_valid && (dist_sq <= diam_sq);
  end
endmodule

// File: rtl/target_tracker.sv
// Multi-slot marker tracker: sequential slot scan per detection, score-based replacement,
// per-frame aging and a registered snapshot published once per frame.
module target_tracker
  import marker_pkg::*;
#(
  parameter int NUM_TARGETS = 4,
  parameter int MAX_MISS    = 2
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic                               frame_start_in,
  input  logic                               det_valid_in,
  output logic                               det_ready_out,
  input  logic [XW-1:0]                      det_x_in,
  input  logic [YW-1:0]                      det_y_in,
  input  logic [YW-1:0]                      det_diam_in,
  input  logic [SCORE_W-1:0]                 det_score_in,
  output logic [NUM_TARGETS-1:0][XW-1:0]     xcount_out,
  output logic [NUM_TARGETS-1:0][YW-1:0]     ycount_out,
  output logic [NUM_TARGETS-1:0][YW-1:0]     diameter_out,
  output logic [NUM_TARGETS-1:0]             valid_out,
  output logic                               frame_done_out,
  output logic [15:0]                        drop_count_out
);
  localparam int IW = $clog2(NUM_TARGETS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_TARGETS - 1);
  localparam logic [3:0] MISS_LIMIT = 4'(MAX_MISS);

  tracker_state_t     state, state_nxt;
  logic               fs_pending, pend_nxt, ready_q, accept;
  logic [IW-1:0]      idx;
  target_slot_t       slots [NUM_TARGETS];
  target_slot_t       aged  [NUM_TARGETS];
  target_slot_t       new_slot;
  logic [XW-1:0]      ev_x;
  logic [YW-1:0]      ev_y, ev_diam;
  logic [SCORE_W-1:0] ev_score, worst_score;
  logic               hit_found, free_found, worst_found;
  logic               hit_seen, free_seen, worst_seen;
  logic [IW-1:0]      hit_idx, free_idx, worst_idx;
  logic               m_hit;
  logic [DW-1:0]      dist_sq_unused;

  target_match u_match (
    .slot_x     (slots[idx].x),
    .slot_y     (slots[idx].y),
    .slot_diam  (slots[idx].diam),
    .slot_valid (slots[idx].valid),
    .ev_x       (ev_x),
    .ev_y       (ev_y),
    .hit        (m_hit),
    .dist_sq    (dist_sq_unused)
  );

  assign det_ready_out = ready_q;
  assign accept        = det_valid_in && ready_q && (state == ST_IDLE);
  assign new_slot      = '{x: ev_x, y: ev_y, diam: ev_diam, score: ev_score,
                           age: 4'd0, seen: 1'b1, valid: 1'b1};
  // Scan trackers restart at slot 0, so earlier-slot results only count once idx has moved on
  assign hit_seen      = hit_found   && (idx != '0);
  assign free_seen     = free_found  && (idx != '0);
  assign worst_seen    = worst_found && (idx != '0);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept) state_nxt = ST_SCAN;
                  else if (fs_pending || frame_start_in) state_nxt = ST_AGE;
      ST_SCAN:    if (idx == LAST_IDX) state_nxt = ST_COMMIT;
      ST_COMMIT:  state_nxt = ST_IDLE;
      ST_AGE:     state_nxt = ST_PUBLISH;
      ST_PUBLISH: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    pend_nxt = fs_pending | frame_start_in;
    if ((state == ST_IDLE) && (state_nxt == ST_AGE)) pend_nxt = 1'b0;
  end

  // Frame-end view of every slot; score goes to all-ones so the next frame's best hit re-centres it
  always_comb begin
    for (int i = 0; i < NUM_TARGETS; i++) begin
      aged[i] = slots[i];
      if (slots[i].valid) begin
        if (slots[i].seen) begin
          aged[i].age = 4'd0;
        end else begin
          aged[i].age = slots[i].age + 4'd1;
          if (slots[i].age + 4'd1 == MISS_LIMIT) aged[i].valid = 1'b0;
        end
        aged[i].seen  = 1'b0;
        aged[i].score = '1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= ST_IDLE;
      fs_pending     <= 1'b0;
      ready_q        <= 1'b0;
      idx            <= '0;
      ev_x           <= '0;
      ev_y           <= '0;
      ev_diam        <= '0;
      ev_score       <= '0;
      hit_found      <= 1'b0;
      free_found     <= 1'b0;
      worst_found    <= 1'b0;
      hit_idx        <= '0;
      free_idx       <= '0;
      worst_idx      <= '0;
      worst_score    <= '0;
      frame_done_out <= 1'b0;
      drop_count_out <= '0;
      xcount_out     <= '0;
      ycount_out     <= '0;
      diameter_out   <= '0;
      valid_out      <= '0;
      for (int i = 0; i < NUM_TARGETS; i++) slots[i] <= '0;
    end else begin
      state          <= state_nxt;
      fs_pending     <= pend_nxt;
      ready_q        <= (state_nxt == ST_IDLE) && !pend_nxt;
      frame_done_out <= (state == ST_AGE);
      case (state)
        ST_IDLE: if (accept) begin
          ev_x     <= det_x_in;
          ev_y     <= det_y_in;
          ev_diam  <= det_diam_in;
          ev_score <= det_score_in;
          idx      <= '0;
        end
        ST_SCAN: begin
          if (!hit_seen && m_hit) begin
            hit_found <= 1'b1;
            hit_idx   <= idx;
          end else begin
            hit_found <= hit_seen;
          end
          if (!free_seen && !slots[idx].valid) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end else begin
            free_found <= free_seen;
          end
          if (slots[idx].valid && (!worst_seen || (slots[idx].score > worst_score))) begin
            worst_found <= 1'b1;
            worst_idx   <= idx;
            worst_score <= slots[idx].score;
          end else begin
            worst_found <= worst_seen;
          end
          idx <= idx + IW'(1);
        end
        ST_COMMIT: begin
          if (hit_found) begin
            slots[hit_idx].seen <= 1'b1;
            if (ev_score < slots[hit_idx].score) begin
              slots[hit_idx].x     <= ev_x;
              slots[hit_idx].y     <= ev_y;
              slots[hit_idx].diam  <= ev_diam;
              slots[hit_idx].score <= ev_score;
            end
          end else if (free_found) begin
            slots[free_idx] <= new_slot;
          end else if (worst_found && (ev_score < worst_score)) begin
            slots[worst_idx] <= new_slot;
          end else if (drop_count_out != 16'hFFFF) begin
            drop_count_out <= drop_count_out + 16'd1;
          end
        end
        // Snapshot is loaded with the aged table so it is fresh while frame_done_out is high
        ST_AGE: begin
          for (int i = 0; i < NUM_TARGETS; i++) begin
            slots[i]        <= aged[i];
            xcount_out[i]   <= aged[i].x;
            ycount_out[i]   <= aged[i].y;
            diameter_out[i] <= aged[i].diam;
            valid_out[i]    <= aged[i].valid;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_target_tracker.sv
// Scoreboard bench for target_tracker: a slot-table model predicts each published snapshot.
module tb_target_tracker;
  import marker_pkg::*;

  localparam int NT = 4;
  localparam int MM = 2;

  logic                      clk_in = 1'b0;
  logic                      rst_n_in = 1'b0;
  logic                      frame_start_in = 1'b0;
  logic                      det_valid_in = 1'b0;
  logic                      det_ready_out;
  logic [XW-1:0]             det_x_in = '0;
  logic [YW-1:0]             det_y_in = '0;
  logic [YW-1:0]             det_diam_in = '0;
  logic [SCORE_W-1:0]        det_score_in = '0;
  logic [NT-1:0][XW-1:0]     xcount_out;
  logic [NT-1:0][YW-1:0]     ycount_out;
  logic [NT-1:0][YW-1:0]     diameter_out;
  logic [NT-1:0]             valid_out;
  logic                      frame_done_out;
  logic [15:0]               drop_count_out;

  target_tracker #(.NUM_TARGETS(NT), .MAX_MISS(MM)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .frame_start_in(frame_start_in),
    .det_valid_in(det_valid_in), .det_ready_out(det_ready_out),
    .det_x_in(det_x_in), .det_y_in(det_y_in), .det_diam_in(det_diam_in),
    .det_score_in(det_score_in), .xcount_out(xcount_out), .ycount_out(ycount_out),
    .diameter_out(diameter_out), .valid_out(valid_out),
    .frame_done_out(frame_done_out), .drop_count_out(drop_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int x, y, d, s, age;
    bit seen, valid;
  } mslot_t;

  typedef struct packed {
    logic [NT-1:0][XW-1:0] x;
    logic [NT-1:0][YW-1:0] y;
    logic [NT-1:0][YW-1:0] d;
    logic [NT-1:0]         v;
    logic [15:0]           drops;
  } snap_t;

  mslot_t m [NT];
  int     m_drops;
  snap_t  exp_q[$];
  snap_t  mon_e;
  int     tests = 0, fails = 0;
  int     fd_count = 0;
  bit     fd_prev = 1'b0;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NT; i++) m[i] = '{0, 0, 0, 0, 0, 1'b0, 1'b0};
    m_drops = 0;
    exp_q.delete();
  endfunction

  function automatic void model_event(int x, int y, int d, int s);
    int hit = -1, free = -1, worst = -1;
    for (int i = 0; i < NT; i++) begin
      int dx = x - m[i].x;
      int dy = y - m[i].y;
      if (m[i].valid && hit < 0 && dx * dx + dy * dy <= m[i].d * m[i].d) hit = i;
      if (!m[i].valid && free < 0) free = i;
      if (m[i].valid && (worst < 0 || m[i].s > m[worst].s)) worst = i;
    end
    if (hit >= 0) begin
      m[hit].seen = 1'b1;
      if (s < m[hit].s) begin
        m[hit].x = x; m[hit].y = y; m[hit].d = d; m[hit].s = s;
      end
    end else if (free >= 0) begin
      m[free] = '{x, y, d, s, 0, 1'b1, 1'b1};
    end else if (s < m[worst].s) begin
      m[worst] = '{x, y, d, s, 0, 1'b1, 1'b1};
    end else if (m_drops < 65535) begin
      m_drops++;
    end
  endfunction

  function automatic void model_frame();
    snap_t e;
    for (int i = 0; i < NT; i++) begin
      if (m[i].valid) begin
        if (m[i].seen) m[i].age = 0;
        else begin
          m[i].age++;
          if (m[i].age == MM) m[i].valid = 1'b0;
        end
        m[i].seen = 1'b0;
        m[i].s = 2047;
      end
      e.x[i] = XW'(m[i].x);
      e.y[i] = YW'(m[i].y);
      e.d[i] = YW'(m[i].d);
      e.v[i] = m[i].valid;
    end
    e.drops = 16'(m_drops);
    exp_q.push_back(e);
  endfunction

  // Monitor: every frame_done_out pulse consumes one predicted snapshot
  always @(negedge clk_in) begin
    if (frame_done_out) begin
      if (fd_prev) check("frame_done_width", 2, 1);
      fd_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_frame_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("snap_valid", int'(valid_out), int'(mon_e.v));
        for (int i = 0; i < NT; i++) begin
          if (mon_e.v[i]) begin
            check($sformatf("snap_x[%0d]", i), int'(xcount_out[i]), int'(mon_e.x[i]));
            check($sformatf("snap_y[%0d]", i), int'(ycount_out[i]), int'(mon_e.y[i]));
            check($sformatf("snap_diam[%0d]", i), int'(diameter_out[i]), int'(mon_e.d[i]));
          end
        end
        check("snap_drop_count", int'(drop_count_out), int'(mon_e.drops));
      end
    end
    fd_prev = frame_done_out;
  end

  task automatic wait_ready(output bit ok);
    int g = 0;
    while (!det_ready_out && g < 200) begin
      @(negedge clk_in);
      g++;
    end
    ok = det_ready_out;
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_frame_done(input int expect_lat, input string name);
    int n = 1;
    while (!frame_done_out && n < 100) begin
      @(posedge clk_in);
      #1;
      n++;
    end
    if (expect_lat > 0) check(name, n, expect_lat);
    else if (!frame_done_out) check("frame_done_timeout", 0, 1);
  endtask

  // mode: 0 = fire and forget, 1 = measure ready return, 2 = wait for frame_done (with_fs)
  task automatic send_event(int x, int y, int d, int s, bit with_fs, int mode);
    bit ok;
    int n;
    @(negedge clk_in);
    wait_ready(ok);
    if (!ok) return;
    det_x_in = XW'(x); det_y_in = YW'(y); det_diam_in = YW'(d); det_score_in = SCORE_W'(s);
    det_valid_in = 1'b1;
    frame_start_in = with_fs;
    @(posedge clk_in);
    #1;
    det_valid_in = 1'b0;
    frame_start_in = 1'b0;
    model_event(x, y, d, s);
    if (with_fs) model_frame();
    if (mode == 1) begin
      check("ready_low_during_scan", int'(det_ready_out), 0);
      n = 1;
      while (!det_ready_out && n < 50) begin
        @(posedge clk_in);
        #1;
        n++;
      end
      check("accept_to_ready_latency", n, NT + 2);
    end else if (mode == 2) begin
      wait_frame_done(NT + 4, "event_plus_frame_latency");
    end
  endtask

  task automatic send_frame(bit measure);
    bit ok;
    @(negedge clk_in);
    wait_ready(ok);
    if (!ok) return;
    frame_start_in = 1'b1;
    @(posedge clk_in);
    #1;
    frame_start_in = 1'b0;
    model_frame();
    wait_frame_done(measure ? 2 : 0, "frame_latency");
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    det_valid_in = 1'b0;
    frame_start_in = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  int cx [6] = '{100, 400, 700, 1000, 200, 900};
  int cy [6] = '{50, 300, 600, 150, 450, 650};

  initial begin
    bit ok;
    int base;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_ready", int'(det_ready_out), 0);
    check("reset_valid", int'(valid_out), 0);
    check("reset_xcount_zero", int'(xcount_out != '0), 0);
    check("reset_frame_done", int'(frame_done_out), 0);
    check("reset_drop_count", int'(drop_count_out), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    check("ready_after_reset", int'(det_ready_out), 1);

    // Single detection then frame
    send_event(100, 50, 20, 300, 1'b0, 1);
    send_frame(1'b1);

    // Hit and re-centre, then allocation of a second slot
    send_event(110, 60, 20, 200, 1'b0, 0);
    send_event(300, 300, 15, 500, 1'b0, 0);
    send_frame(1'b0);
    check("two_slots_valid", int'(valid_out), 3);
    check("slot0_recentred_x", int'(xcount_out[0]), 110);

    // Full table: replace worst (score 900, lowest index), then drop
    do_reset();
    send_event(100, 100, 10, 100, 1'b0, 0);
    send_event(400, 100, 10, 900, 1'b0, 0);
    send_event(700, 100, 10, 400, 1'b0, 0);
    send_event(1000, 100, 10, 900, 1'b0, 0);
    send_event(100, 600, 10, 500, 1'b0, 0);
    send_event(700, 600, 10, 950, 1'b0, 0);
    send_frame(1'b0);
    check("drop_count_after_full", int'(drop_count_out), 1);
    check("slot1_replaced_y", int'(ycount_out[1]), 600);

    // Aging out after MAX_MISS missed frames, and a hit resetting the age
    do_reset();
    send_event(200, 200, 20, 100, 1'b0, 0);
    send_frame(1'b0);
    send_frame(1'b0);
    check("age_one_miss_valid", int'(valid_out[0]), 1);
    send_frame(1'b0);
    check("age_two_miss_invalid", int'(valid_out[0]), 0);
    send_event(500, 500, 20, 100, 1'b0, 0);
    send_frame(1'b0);
    send_frame(1'b0);
    send_event(505, 505, 20, 300, 1'b0, 0);
    send_frame(1'b0);
    send_frame(1'b0);
    check("hit_resets_age", int'(valid_out[0]), 1);

    // Frame pulse coinciding with an accepted event
    send_event(600, 400, 15, 200, 1'b1, 2);

    // Two frame pulses during one scan merge into a single frame
    @(negedge clk_in);
    wait_ready(ok);
    det_x_in = XW'(900); det_y_in = YW'(100); det_diam_in = YW'(12); det_score_in = SCORE_W'(50);
    det_valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    det_valid_in = 1'b0;
    model_event(900, 100, 12, 50);
    model_frame();
    base = fd_count;
    @(negedge clk_in); frame_start_in = 1'b1;
    @(negedge clk_in); frame_start_in = 1'b0;
    @(negedge clk_in); frame_start_in = 1'b1;
    @(negedge clk_in); frame_start_in = 1'b0;
    repeat (20) @(negedge clk_in);
    check("merged_frame_count", fd_count - base, 1);

    // Reset in the middle of a scan
    @(negedge clk_in);
    wait_ready(ok);
    det_x_in = XW'(50); det_y_in = YW'(50); det_diam_in = YW'(10); det_score_in = SCORE_W'(10);
    det_valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    det_valid_in = 1'b0;
    @(posedge clk_in);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("async_reset_valid", int'(valid_out), 0);
    check("async_reset_xcount_zero", int'(xcount_out != '0), 0);
    check("async_reset_ready", int'(det_ready_out), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    model_reset();
    send_frame(1'b1);
    check("no_partial_update", int'(valid_out), 0);

    // Randomised traffic against the model
    do_reset();
    for (int k = 0; k < 300; k++) begin
      int r = int'($urandom_range(0, 9));
      if (r < 2) begin
        send_frame(1'b0);
      end else begin
        int c = int'($urandom_range(0, 5));
        int x, y, d, s;
        if ($urandom_range(0, 7) == 0) begin
          x = int'($urandom_range(0, 1279));
          y = int'($urandom_range(0, 719));
        end else begin
          x = cx[c] + int'($urandom_range(0, 20)) - 10;
          y = cy[c] + int'($urandom_range(0, 20)) - 10;
        end
        d = int'($urandom_range(8, 24));
        s = int'($urandom_range(0, 2046));
        if (r == 9) send_event(x, y, d, s, 1'b1, 2);
        else send_event(x, y, d, s, 1'b0, 0);
      end
    end
    send_frame(1'b0);
    repeat (4) @(negedge clk_in);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
